// File: rtl/de_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller (optional HAZARD_PERF_EN perf counters live in the top).
// Holds the FSM encoding, pending-write counter sizing and the controller-to-FE bundle width.
`ifndef DE_HAZARD_CTRL_PKG_SV
`define DE_HAZARD_CTRL_PKG_SV

`define HZ_FE_BUS_W 2

package de_hazard_ctrl_pkg;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [0:0] {
    HZ_RUN     = 1'b0,
    HZ_BR_WAIT = 1'b1
  } hz_state_e;
endpackage

`endif

// File: rtl/de_hazard_ctrl_scoreboard.sv
// Per-register pending-write counters with retire/kill decrement, clamp at 0, registered busy_mask.
// Source-busy answers are combinational on post-decrement counters; saturation uses the current count.
module hz_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_vld,
  input  logic [4:0]       inc_reg,
  input  logic             ret_vld,
  input  logic [4:0]       ret_reg,
  input  logic             kill_vld,
  input  logic [4:0]       kill_reg,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_sat,
  output logic [NREGS-1:0] busy_mask
);

  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_dec [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [1:0]       ndec;

  always_comb begin
    ndec = 2'd0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_dec[i] = cnt[i];
      cnt_nxt[i] = cnt[i];
    end
    // Entry 0 is never touched, so x0 retire/kill/issue fall through.
    for (int i = 1; i < NREGS; i++) begin
      ndec = {1'b0, ret_vld && (ret_reg == 5'(i))} + {1'b0, kill_vld && (kill_reg == 5'(i))};
      if ({2'b00, cnt[i]} >= (CNT_W + 2)'(ndec))
        cnt_dec[i] = cnt[i] - CNT_W'(ndec);
      else
        cnt_dec[i] = '0;
      cnt_nxt[i] = cnt_dec[i] + CNT_W'(inc_vld && (inc_reg == 5'(i)));
    end
  end

  assign rs1_busy = (cnt_dec[rs1] != '0);
  assign rs2_busy = (cnt_dec[rs2] != '0);
  assign rd_sat   = (cnt[rd] == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      busy_mask <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i]       <= cnt_nxt[i];
        busy_mask[i] <= (cnt_nxt[i] != '0);
      end
    end
  end

endmodule

// File: rtl/de_hazard_ctrl.sv
// Decode-stage issue controller: scoreboard RAW/saturation checks, branch wait FSM, MUL occupancy timer.
// issue/stall_de/fe_hold are combinational this cycle; HAZARD_PERF_EN adds 32-bit stall-cause counters.
module de_hazard_ctrl
  import de_hazard_ctrl_pkg::hz_state_e;
  import de_hazard_ctrl_pkg::HZ_RUN;
  import de_hazard_ctrl_pkg::HZ_BR_WAIT;
#(
  parameter int NREGS   = 32,
  parameter int CNT_W   = de_hazard_ctrl_pkg::CNT_W,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_valid,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_use_rs1,
  input  logic             de_use_rs2,
  input  logic             de_wr_reg,
  input  logic [4:0]       de_rd,
  input  logic             de_is_branch,
  input  logic             de_is_mul,
  input  logic             br_resolve,
  input  logic             wb_wr_reg,
  input  logic [4:0]       wb_regno,
  input  logic             kill_valid,
  input  logic [4:0]       kill_regno,
  output logic             issue,
  output logic             stall_de,
  output logic             fe_hold,
  output logic [NREGS-1:0] busy_mask
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_raw_stalls,
  output logic [31:0]      perf_br_stalls,
  output logic [31:0]      perf_mul_stalls
`endif
);

  localparam int MW = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

  hz_state_e     state, state_nxt;
  logic [MW-1:0] mul_cnt, mul_nxt;
  logic          mul_busy;
  logic          rs1_busy, rs2_busy, rd_sat;
  logic          raw, sat;

  hz_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .inc_vld   (issue && de_wr_reg && (de_rd != 5'd0)),
    .inc_reg   (de_rd),
    .ret_vld   (wb_wr_reg),
    .ret_reg   (wb_regno),
    .kill_vld  (kill_valid),
    .kill_reg  (kill_regno),
    .rs1       (de_rs1),
    .rs2       (de_rs2),
    .rd        (de_rd),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rd_sat    (rd_sat),
    .busy_mask (busy_mask)
  );

  assign raw      = (de_use_rs1 && (de_rs1 != 5'd0) && rs1_busy) ||
                    (de_use_rs2 && (de_rs2 != 5'd0) && rs2_busy);
  assign sat      = de_wr_reg && (de_rd != 5'd0) && rd_sat;
  assign mul_busy = (mul_cnt != '0);
  assign stall_de = de_valid && !issue;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    fe_hold   = 1'b0;
    case (state)
      HZ_RUN: begin
        issue = de_valid && !raw && !sat && !mul_busy;
        if (issue && de_is_branch) state_nxt = HZ_BR_WAIT;
      end
      HZ_BR_WAIT: begin
        fe_hold = !br_resolve;
        if (br_resolve) state_nxt = HZ_RUN;
      end
      default: state_nxt = HZ_RUN;
    endcase
  end

  always_comb begin
    mul_nxt = mul_cnt;
    if (issue && de_is_mul) mul_nxt = MW'(MUL_LAT - 1);
    else if (mul_busy)      mul_nxt = mul_cnt - MW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HZ_RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  // Stall cause priority: branch wait, then MUL occupancy, then operand/saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_raw_stalls <= '0;
      perf_br_stalls  <= '0;
      perf_mul_stalls <= '0;
    end else if (stall_de) begin
      if (state == HZ_BR_WAIT) perf_br_stalls  <= perf_br_stalls + 32'd1;
      else if (mul_busy)       perf_mul_stalls <= perf_mul_stalls + 32'd1;
      else                     perf_raw_stalls <= perf_raw_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_de_hazard_ctrl.sv
// Directed vector bench for de_hazard_ctrl: cycle-by-cycle table plus reset/MUL corner sequences.
module tb_de_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid, de_use_rs1, de_use_rs2, de_wr_reg, de_is_branch, de_is_mul;
  logic [4:0]  de_rs1, de_rs2, de_rd, wb_regno, kill_regno;
  logic        br_resolve, wb_wr_reg, kill_valid;
  logic        issue, stall_de, fe_hold;
  logic [31:0] busy_mask;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_raw_stalls, perf_br_stalls, perf_mul_stalls;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  de_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .de_valid     (de_valid),
    .de_rs1       (de_rs1),
    .de_rs2       (de_rs2),
    .de_use_rs1   (de_use_rs1),
    .de_use_rs2   (de_use_rs2),
    .de_wr_reg    (de_wr_reg),
    .de_rd        (de_rd),
    .de_is_branch (de_is_branch),
    .de_is_mul    (de_is_mul),
    .br_resolve   (br_resolve),
    .wb_wr_reg    (wb_wr_reg),
    .wb_regno     (wb_regno),
    .kill_valid   (kill_valid),
    .kill_regno   (kill_regno),
    .issue        (issue),
    .stall_de     (stall_de),
    .fe_hold      (fe_hold),
    .busy_mask    (busy_mask)
`ifdef HAZARD_PERF_EN
    ,
    .perf_raw_stalls (perf_raw_stalls),
    .perf_br_stalls  (perf_br_stalls),
    .perf_mul_stalls (perf_mul_stalls)
`endif
  );

  typedef struct {
    logic        vld;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, wr;
    logic [4:0]  rd;
    logic        br, mul, res, wb;
    logic [4:0]  wbno;
    logic        kill;
    logic [4:0]  killno;
    logic        e_issue, e_stall, e_hold;
    logic [31:0] e_mask;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int vld, int rs1, int rs2, int u1, int u2, int wr, int rd,
                              int br, int mul, int res, int wb, int wbno, int kill, int killno,
                              int ei, int es, int eh, int mbit);
    vec_t v;
    v.vld = 1'(vld); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.u1 = 1'(u1); v.u2 = 1'(u2); v.wr = 1'(wr); v.rd = 5'(rd);
    v.br = 1'(br); v.mul = 1'(mul); v.res = 1'(res);
    v.wb = 1'(wb); v.wbno = 5'(wbno); v.kill = 1'(kill); v.killno = 5'(killno);
    v.e_issue = 1'(ei); v.e_stall = 1'(es); v.e_hold = 1'(eh);
    v.e_mask = (mbit < 0) ? 32'h0 : (32'h1 << mbit);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    de_valid = v.vld; de_rs1 = v.rs1; de_rs2 = v.rs2;
    de_use_rs1 = v.u1; de_use_rs2 = v.u2; de_wr_reg = v.wr; de_rd = v.rd;
    de_is_branch = v.br; de_is_mul = v.mul; br_resolve = v.res;
    wb_wr_reg = v.wb; wb_regno = v.wbno; kill_valid = v.kill; kill_regno = v.killno;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step_check(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    chk("issue",     idx, {31'b0, issue},    {31'b0, v.e_issue});
    chk("stall_de",  idx, {31'b0, stall_de}, {31'b0, v.e_stall});
    chk("fe_hold",   idx, {31'b0, fe_hold},  {31'b0, v.e_hold});
    chk("busy_mask", idx, busy_mask,         v.e_mask);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,-1);

    //        vld rs1 rs2 u1 u2 wr rd  br mul res wb no kl no  iss stl hld mbit
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, -1)); // 0 reset state
    vq.push_back(mk(1, 1, 0, 1, 0, 1, 5,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0, -1)); // 1 ADD x5
    vq.push_back(mk(1, 5, 0, 1, 0, 1, 6,  0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  5)); // 2 RAW x5
    vq.push_back(mk(1, 5, 0, 1, 0, 1, 6,  0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  5)); // 3
    vq.push_back(mk(1, 5, 0, 1, 0, 1, 6,  0, 0, 0,  1, 5, 0, 0,  1, 0, 0,  5)); // 4 retire frees
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 6, 0, 0,  0, 0, 0,  6)); // 5
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, -1)); // 6
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0, -1)); // 7 x7 #1
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  7)); // 8 x7 #2
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  7)); // 9 x7 #3
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  7)); // 10 sat
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7,  0, 0, 0,  1, 7, 1, 0,  0, 1, 0,  7)); // 11 sat, retire, kill x0
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  7)); // 12 issues
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 7, 1, 7,  0, 0, 0,  7)); // 13 3->1
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 7, 0, 0,  0, 0, 0,  7)); // 14 1->0
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, -1)); // 15
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 3,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0, -1)); // 16 x3 pending
    vq.push_back(mk(1, 0, 3, 0, 1, 0, 0,  0, 0, 0,  1, 3, 1, 3,  1, 0, 0,  3)); // 17 kill+retire
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, -1)); // 18 no underflow
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 9,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0, -1)); // 19
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 9,  0, 0, 0,  1, 9, 0, 0,  1, 0, 0,  9)); // 20 issue+retire
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  9)); // 21 net 0
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 9, 0, 0,  0, 0, 0,  9)); // 22
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, -1)); // 23
    vq.push_back(mk(1, 0, 0, 1, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0,  1, 0, 0, -1)); // 24 x0 untracked
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, -1)); // 25
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0,  1, 0, 0, -1)); // 26 BEQ
    vq.push_back(mk(1, 1, 2, 1, 1, 1, 4,  0, 0, 0,  0, 0, 0, 0,  0, 1, 1, -1)); // 27 BR_WAIT
    vq.push_back(mk(1, 1, 2, 1, 1, 1, 4,  0, 0, 0,  0, 0, 0, 0,  0, 1, 1, -1)); // 28
    vq.push_back(mk(1, 1, 2, 1, 1, 1, 4,  0, 0, 0,  0, 0, 0, 0,  0, 1, 1, -1)); // 29
    vq.push_back(mk(1, 1, 2, 1, 1, 1, 4,  0, 0, 1,  0, 0, 0, 0,  0, 1, 0, -1)); // 30 resolve
    vq.push_back(mk(1, 1, 2, 1, 1, 1, 4,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0, -1)); // 31 RUN again
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 4, 0, 0,  0, 0, 0,  4)); // 32 resolve in RUN
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0, -1)); // 33
    vq.push_back(mk(1, 1, 2, 1, 1, 1,10,  0, 1, 0,  0, 0, 0, 0,  1, 0, 0, -1)); // 34 MUL
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 10)); // 35 mul busy
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 10)); // 36
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0,  0, 0, 0,  1,10, 0, 0,  1, 0, 0, 10)); // 37 issues
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, -1)); // 38

    drive(idle);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) step_check(vq[i], i);

`ifdef HAZARD_PERF_EN
    chk("perf_br",  0, perf_br_stalls,  32'd4);
    chk("perf_mul", 0, perf_mul_stalls, 32'd2);
    chk("perf_raw", 0, perf_raw_stalls, 32'd4);
`endif

    // Reset while waiting on a branch with a pending write.
    step_check(mk(1,0,0,0,0,1,12, 0,0,0, 0,0,0,0, 1,0,0,-1), 100);
    step_check(mk(1,0,0,0,0,0,0,  1,0,0, 0,0,0,0, 1,0,0,12), 101);
    step_check(mk(0,0,0,0,0,0,0,  0,0,0, 0,0,0,0, 0,0,1,12), 102);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step_check(mk(0,0,0,0,0,0,0,  0,0,0, 0,0,0,0, 0,0,0,-1), 103);
`ifdef HAZARD_PERF_EN
    chk("perf_br_rst",  1, perf_br_stalls,  32'd0);
    chk("perf_mul_rst", 1, perf_mul_stalls, 32'd0);
    chk("perf_raw_rst", 1, perf_raw_stalls, 32'd0);
`endif
    step_check(mk(1,1,0,1,0,0,0,  0,0,0, 0,0,0,0, 1,0,0,-1), 104);

    // Reset during MUL occupancy clears the timer.
    step_check(mk(1,0,0,0,0,0,0,  0,1,0, 0,0,0,0, 1,0,0,-1), 105);
    step_check(mk(1,0,0,0,0,0,0,  0,0,0, 0,0,0,0, 0,1,0,-1), 106);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step_check(mk(1,0,0,0,0,0,0,  0,0,0, 0,0,0,0, 1,0,0,-1), 107);
    step_check(idle, 108);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/de_hazard_ctrl.md
Name: de_hazard_ctrl

Overview:
- Scoreboard-based issue controller for the decode stage.
- Tracks pending register writes in flight (AGEX/MEM/WB) with per-register counters.
- Sequences branch-resolution waits and multi-cycle MUL occupancy.
- Drives the DE stall/bubble and FE hold signals, replacing the combinational stage-compare stall logic.

Parameters:
- NREGS, 32, architectural registers tracked; x0 is never tracked.
- CNT_W, 2, per-register pending-write counter width; CNT_MAX = 2^CNT_W-1.
- MUL_LAT, 3, cycles the MUL unit is occupied after a MUL issues (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- de_valid  in  1  DE holds a valid decoded instruction
- de_rs1, de_rs2  in  5 each  source register numbers
- de_use_rs1, de_use_rs2  in  1 each  source actually read
- de_wr_reg  in  1  instruction writes rd
- de_rd  in  5  destination register
- de_is_branch  in  1  BEQ..BGEU/JAL/JALR
- de_is_mul  in  1  MUL_I
- br_resolve  in  1  AGEX pulse: outstanding branch resolved
- wb_wr_reg  in  1  WB retiring a register write
- wb_regno  in  5  WB destination
- kill_valid  in  1  AGEX squashing one in-flight writer
- kill_regno  in  5  squashed writer's rd
- issue  out  1  DE instruction enters DE latch this cycle
- stall_de  out  1  hold FE latch, write bubble into DE latch
- fe_hold  out  1  FE must not fetch (branch outstanding)
- busy_mask  out  NREGS  bit i = cnt[i]!=0 (bit 0 always 0)

Behaviour:
- Reset: all counters 0, state RUN, MUL counter 0; issue=0, stall_de=0, fe_hold=0, busy_mask=0.
- Source readiness is evaluated on counters after this cycle's retire/kill decrements. WB writes on negedge, so a same-cycle retire frees the source.
- raw = (use_rs1 && rs1!=0 && cnt'[rs1]!=0) || (use_rs2 && rs2!=0 && cnt'[rs2]!=0).
- sat = de_wr_reg && de_rd!=0 && cnt[de_rd]==CNT_MAX.
- FSM states:
  - RUN: issue = de_valid && !raw && !sat && !mul_busy.
    - Issued branch -> BR_WAIT.
    - Issued MUL -> mul counter loads MUL_LAT-1; stays RUN.
  - BR_WAIT: fe_hold=1, issue=0. On br_resolve -> RUN; fe_hold drops the same cycle (combinational from state and br_resolve).
- mul_busy = mul counter != 0. The counter decrements each cycle toward 0 and never underflows.
- stall_de = de_valid && !issue.
- Counter update per cycle: +1 if issue && de_wr_reg && de_rd!=0; −1 per retire matching; −1 per kill matching; result clamped at 0.
  - Issue+retire to the same reg: net 0.
  - Retire+kill to the same reg: −2, floor 0.
- br_resolve in RUN is ignored.
- Kill/retire of x0 is ignored.
- reset mid-BR_WAIT or mid-MUL returns to RUN with idle counters the next cycle.
- busy_mask is registered: reflects counter state, one cycle after update.

Optional Feature:
- HAZARD_PERF_EN
- Defined: adds outputs perf_raw_stalls, perf_br_stalls, perf_mul_stalls (32 bits each, wrap on overflow).
  - Increment on cycles where de_valid && !issue, attributed by priority br > mul > raw/sat.
  - Cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/define header:
  - FSM state encoding (HZ_RUN, HZ_BR_WAIT).
  - CNT_W/CNT_MAX.
  - Width macro for the controller-to-FE bundle.
- Sub-module hz_scoreboard: counter array, update/clamp logic, busy_mask.
- FSM and MUL timer stay in the top module.

Test Plan:
- Issue ADD x5 (wr) then ADD reading x5 next cycle -> second stalls (stall_de=1, issue=0) until wb_wr_reg with wb_regno=5; issues that same cycle; busy_mask[5] 1→0.
- Three back-to-back writes to x7 with no retire -> cnt[7]=3; fourth writer to x7 stalls (sat) until one retire, then issues.
- Issue BEQ -> fe_hold=1 from next cycle; de_valid ignored; br_resolve after 4 cycles -> fe_hold=0 that cycle, state RUN.
- Issue MUL with MUL_LAT=3 -> next two cycles issue=0 for any valid instruction; third cycle issues.
- Pending x3 (cnt=1), kill_valid with kill_regno=3 and wb retire x3 same cycle -> cnt[3]=0 (no underflow); reader of x3 issues that cycle.
- Assert reset during BR_WAIT with busy_mask≠0 -> next cycle fe_hold=0, busy_mask=0, RUN; with HAZARD_PERF_EN, all perf counters 0.
